// File: rtl/branch_predict_unit.sv
// branch_predict_unit: bimodal branch predictor with branch resolution.
//   A table of BHT_DEPTH 2-bit saturating counters provides a zero-latency
//   taken/not-taken prediction for the fetch PC. The execute-stage side
//   evaluates the branch condition and decides on a redirect and its target
//   source. It also trains the table on every conditional branch that
//   resolves cleanly.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   lookup_pc_i           fetch PC; predict_taken_o is its prediction
//   resolve_valid_i       execute-stage instruction valid
//   resolve_pc_i          PC of the resolving instruction (update index)
//   rs1_i, rs2_i          branch compare operands
//   funct3_i              branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   branch_jump_op_i      [1] conditional branch, [0] unconditional jump
//   pred_taken_i          prediction carried with the instruction
//   is_mret_i             MRET instruction
//   exception_i           nonzero = exception
//   redirect_o            flush front end and redirect fetch (combinational)
//   target_sel_o          00 ALU, 01 MTVEC, 10 MEPC, 11 PC+4 (combinational)
//   mispredict_o          conditional branch resolved against its prediction
// Optional feature, macro BP_PERF_CNT_EN: adds branch_cnt_o and
//   mispredict_cnt_o. These are 32-bit wrapping counters of table updates and
//   mispredicts.
module branch_predict_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            predict_taken_o,
  input  logic            resolve_valid_i,
  input  logic [XLEN-1:0] resolve_pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      branch_jump_op_i,
  input  logic            pred_taken_i,
  input  logic            is_mret_i,
  input  logic [1:0]      exception_i,
`ifdef BP_PERF_CNT_EN
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o,
`endif
  output logic            redirect_o,
  output logic [1:0]      target_sel_o,
  output logic            mispredict_o
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [1:0] TGT_ALU   = 2'b00;
  localparam logic [1:0] TGT_MTVEC = 2'b01;
  localparam logic [1:0] TGT_MEPC  = 2'b10;
  localparam logic [1:0] TGT_FALL  = 2'b11;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic             cond;
  logic             exc;
  logic             act;
  logic             br;
  logic             jmp;
  logic             update_en;

  // PC bits outside the index field do not affect the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0],
                            resolve_pc_i[XLEN-1:IDX_W+2], resolve_pc_i[1:0]};

  assign lookup_idx = lookup_pc_i[IDX_W+1:2];
  assign update_idx = resolve_pc_i[IDX_W+1:2];

  assign exc = |exception_i;
  assign act = resolve_valid_i;
  assign br  = branch_jump_op_i[1];
  assign jmp = branch_jump_op_i[0];

  // Zero-latency read; forced low while the table is held in reset
  assign predict_taken_o = rst_i ? 1'b0 : bht[lookup_idx][1];

  // Branch condition; undefined funct3 encodings evaluate to not-taken
  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      3'b000:  cond = (rs1_i == rs2_i);
      3'b001:  cond = (rs1_i != rs2_i);
      3'b100:  cond = ($signed(rs1_i) <  $signed(rs2_i));
      3'b101:  cond = ($signed(rs1_i) >= $signed(rs2_i));
      3'b110:  cond = (rs1_i <  rs2_i);
      3'b111:  cond = (rs1_i >= rs2_i);
      default: cond = 1'b0;
    endcase
  end

  assign mispredict_o = act && !exc && !is_mret_i && br && (cond != pred_taken_i);
  assign redirect_o   = act && (exc || is_mret_i || jmp || mispredict_o);
  assign update_en    = act && br && !exc && !is_mret_i;

  // Redirect target priority; ALU whenever no redirect is requested
  always_comb begin
    target_sel_o = TGT_ALU;
    if (redirect_o) begin
      if (exc)              target_sel_o = TGT_MTVEC;
      else if (is_mret_i)   target_sel_o = TGT_MEPC;
      else if (jmp || cond) target_sel_o = TGT_ALU;
      else                  target_sel_o = TGT_FALL;
    end
  end

  // Counter table: saturating train on clean conditional branches
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht[i] <= CNT_WNT;
    end else if (update_en) begin
      if (cond) begin
        if (bht[update_idx] != CNT_ST) bht[update_idx] <= bht[update_idx] + 2'd1;
      end else begin
        if (bht[update_idx] != CNT_SNT) bht[update_idx] <= bht[update_idx] - 2'd1;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  // Free-running event counters, wrap at 2^32
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o     <= 32'd0;
      mispredict_cnt_o <= 32'd0;
    end else begin
      if (update_en)    branch_cnt_o     <= branch_cnt_o + 32'd1;
      if (mispredict_o) mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk_i and rst_i.
REQ-002 Parameter XLEN, default 32: operand width in bits.
REQ-003 Parameter BHT_DEPTH, default 64: number of branch-history-table entries; a power of two, 2..1024.
REQ-004 Localparam IDX_W SHALL equal log2(BHT_DEPTH).
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 lookup_pc_i  in  XLEN  fetch-stage PC.
REQ-008 predict_taken_o  out  1  prediction for lookup_pc_i.
REQ-009 resolve_valid_i  in  1  execute-stage instruction valid.
REQ-010 resolve_pc_i  in  XLEN  PC of the resolving instruction.
REQ-011 rs1_i, rs2_i  in  XLEN  branch compare operands.
REQ-012 funct3_i  in  3  branch type: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
REQ-013 branch_jump_op_i  in  2  bit1 = conditional branch, bit0 = unconditional jump.
REQ-014 pred_taken_i  in  1  prediction that travelled down the pipe with the instruction.
REQ-015 is_mret_i  in  1  MRET instruction.
REQ-016 exception_i  in  2  nonzero = exception.
REQ-017 redirect_o  out  1  flush the front end and redirect fetch.
REQ-018 target_sel_o  out  2  redirect target: ALU 00, MTVEC 01, MEPC 10, FALLTHROUGH (PC+4) 11.
REQ-019 mispredict_o  out  1  conditional branch resolved against its prediction.

Function
REQ-020 Each table entry SHALL be a 2-bit saturating counter: SNT 00, WNT 01, WT 10, ST 11.
REQ-021 The lookup index SHALL be lookup_pc_i[IDX_W+1:2]; the update index SHALL be resolve_pc_i[IDX_W+1:2].
REQ-022 predict_taken_o SHALL be the MSB of the indexed entry, read combinationally with zero latency.
REQ-023 cond SHALL be computed from funct3_i: equal, not equal, signed <, signed >=, unsigned <, unsigned >=.
REQ-024 For undefined funct3 values, cond SHALL be 0.
REQ-025 exc = |exception_i; act = resolve_valid_i; br = branch_jump_op_i[1]; jmp = branch_jump_op_i[0].
REQ-026 mispredict_o = act && !exc && !is_mret_i && br && (cond != pred_taken_i).
REQ-027 redirect_o = act && (exc || is_mret_i || jmp || mispredict_o).
REQ-028 Target priority: exc -> MTVEC; else is_mret_i -> MEPC; else jmp, or br mispredicted taken -> ALU; else br mispredicted not-taken -> FALLTHROUGH.
REQ-029 When redirect_o=0, target_sel_o SHALL be ALU.
REQ-030 redirect_o, target_sel_o and mispredict_o SHALL be combinational (same cycle as the resolve inputs).
REQ-031 Table update: on a clock edge with act && br && !exc && !is_mret_i, the entry SHALL increment toward 11 if cond, else decrement toward 00.
REQ-032 The counter SHALL saturate: it holds at 11 when taken and at 00 when not taken.
REQ-033 Jumps, MRET, exceptions and invalid cycles SHALL NOT modify the table.
REQ-034 A lookup and an update to the same index in one cycle SHALL return the pre-update value (read-before-write).

Reset
REQ-035 rst_i SHALL asynchronously set every table entry to WNT (01), whether or not an update is in flight.
REQ-036 While reset is asserted, predict_taken_o SHALL read 0.
REQ-037 Combinational outputs SHALL follow their inputs during reset; the pipeline gates them with valid.

Configuration
REQ-038 With macro BP_PERF_CNT_EN defined, the block SHALL add outputs branch_cnt_o[31:0] and mispredict_cnt_o[31:0].
REQ-039 branch_cnt_o SHALL count table-update cycles; mispredict_cnt_o SHALL count cycles with mispredict_o=1.
REQ-040 Both counters SHALL reset to 0 and wrap from 0xFFFFFFFF to 0.
REQ-041 Without BP_PERF_CNT_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-042 Reset, then lookup_pc_i=0x100 -> predict_taken_o=0 (entry WNT).
REQ-043 Two taken BEQ at PC 0x100 (rs1=rs2=5, pred_taken_i=0, then 1) -> first mispredict_o=1, target ALU; then entry=ST and predict_taken_o=1.
REQ-044 BLT with rs1=0xFFFFFFFF, rs2=1, pred_taken_i=1 -> cond=1, mispredict_o=0, redirect_o=0.
REQ-045 BLTU with the same operands, pred_taken_i=1 -> mispredict_o=1, target_sel_o=11, entry decrements.
REQ-046 exception_i=01 together with a taken branch -> redirect_o=1, target_sel_o=01, table unchanged.
REQ-047 With BP_PERF_CNT_EN, 3 branches including 1 mispredict -> branch_cnt_o=3, mispredict_cnt_o=1; a mid-run reset clears both and all entries to 01.
